pcs_rx_align_ctrl: RTL and testbench

//  Word-alignment controller in front of the clause-36 PCS synchronizer.

---
 rtl/pcs_rx_align_ctrl_pkg.sv | 25 ++
 rtl/pcs_rx_align_ctrl_comma_scan.sv | 23 ++
 rtl/pcs_rx_align_ctrl.sv | 135 +++++++++++++
 tb/tb_pcs_rx_align_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pcs_rx_align_ctrl_pkg.sv
// Shared constants and helpers for the PCS receive word aligner:
// one-hot state encodings, comma patterns, offset width and window slicing.
package pcs_rx_align_ctrl_pkg;

  localparam int OFFSET_W = 4;
  localparam int STATE_W  = 3;

  localparam logic [STATE_W-1:0] ST_SEARCH = 3'b001;
  localparam logic [STATE_W-1:0] ST_VERIFY = 3'b010;
  localparam logic [STATE_W-1:0] ST_LOCKED = 3'b100;

  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_M = 7'b1100000;

  // Candidate k is win[19-k:10-k]; win[19] is the oldest bit received.
  function automatic logic [9:0] candidate(input logic [19:0] win,
                                           input logic [OFFSET_W-1:0] k);
    return win[5'd10 - {1'b0, k} +: 10];
  endfunction

  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_P) || (cg[9:3] == COMMA_M);
  endfunction

endpackage

// File: rtl/pcs_rx_align_ctrl_comma_scan.sv
// Combinational comma search over all ten bit offsets of a 20-bit window.
// The lowest matching offset is reported when several match.
module pcs_comma_scan
  import pcs_rx_align_ctrl_pkg::*;
(
  input  logic [19:0]         win,
  output logic                found,
  output logic [OFFSET_W-1:0] k
);

  // Scanning from the top down lets the lowest matching offset overwrite the rest.
  always_comb begin
    found = 1'b0;
    k     = '0;
    for (int i = 9; i >= 0; i--) begin
      if (is_comma(candidate(win, OFFSET_W'(i)))) begin
        found = 1'b1;
        k     = OFFSET_W'(i);
      end
    end
  end

endmodule

// File: rtl/pcs_rx_align_ctrl.sv
// Word-alignment controller ahead of the clause-36 PCS synchronizer.
// Optional realign statistics counter is built when PCS_ALIGN_STATS_EN is defined.
module pcs_rx_align_ctrl
  import pcs_rx_align_ctrl_pkg::*;
#(
  parameter int VERIFY_TIMEOUT = 64,
  parameter int LOSS_FILTER    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid_in,
  input  logic [9:0]          rx_raw,
  input  logic                sync_status,
  output logic [9:0]          rx_code_group,
  output logic                pudi,
  output logic                aligned,
  output logic [OFFSET_W-1:0] offset,
  output logic                realign
`ifdef PCS_ALIGN_STATS_EN
 ,output logic [15:0]         realign_cnt
`endif
);

  localparam int VT_W = $clog2(VERIFY_TIMEOUT + 1);
  localparam int LF_W = $clog2(LOSS_FILTER + 1);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [VT_W-1:0]     verify_timer_q, verify_timer_d;
  logic [LF_W-1:0]     loss_timer_q, loss_timer_d;
  logic                realign_q, realign_d;
  logic [9:0]          prev_q;
  logic [9:0]          code_group_q;
  logic                pudi_q;

  logic [19:0]         win;
  logic                comma_found;
  logic [OFFSET_W-1:0] comma_k;

  assign win = {prev_q, rx_raw};

  pcs_comma_scan u_scan (
    .win   (win),
    .found (comma_found),
    .k     (comma_k)
  );

  // VERIFY watches sync_status every clock; LOCKED counts loss in clocks, not words.
  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    verify_timer_d = verify_timer_q;
    loss_timer_d   = loss_timer_q;
    realign_d      = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (rx_valid_in && comma_found) begin
          offset_d       = comma_k;
          verify_timer_d = '0;
          state_d        = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (sync_status) begin
          loss_timer_d = '0;
          state_d      = ST_LOCKED;
        end else if (rx_valid_in) begin
          if (verify_timer_q == VT_W'(VERIFY_TIMEOUT - 1)) begin
            state_d   = ST_SEARCH;
            realign_d = 1'b1;
          end else begin
            verify_timer_d = verify_timer_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (sync_status) begin
          loss_timer_d = '0;
        end else if (loss_timer_q == LF_W'(LOSS_FILTER - 1)) begin
          state_d   = ST_SEARCH;
          realign_d = 1'b1;
        end else begin
          loss_timer_d = loss_timer_q + 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_SEARCH;
      offset_q       <= '0;
      verify_timer_q <= '0;
      loss_timer_q   <= '0;
      realign_q      <= 1'b0;
      prev_q         <= '0;
      code_group_q   <= '0;
      pudi_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      offset_q       <= offset_d;
      verify_timer_q <= verify_timer_d;
      loss_timer_q   <= loss_timer_d;
      realign_q      <= realign_d;
      pudi_q         <= rx_valid_in;
      // The forwarded word uses the offset in force before this cycle's search result.
      if (rx_valid_in) begin
        prev_q       <= rx_raw;
        code_group_q <= candidate(win, offset_q);
      end
    end
  end

`ifdef PCS_ALIGN_STATS_EN
  logic [15:0] realign_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      realign_cnt_q <= '0;
    end else if (realign_d && (realign_cnt_q != 16'hFFFF)) begin
      realign_cnt_q <= realign_cnt_q + 16'd1;
    end
  end

  assign realign_cnt = realign_cnt_q;
`endif

  assign rx_code_group = code_group_q;
  assign pudi          = pudi_q;
  assign aligned       = (state_q == ST_LOCKED);
  assign offset        = offset_q;
  assign realign       = realign_q;

endmodule

// File: tb/tb_pcs_rx_align_ctrl.sv
// Directed bench for pcs_rx_align_ctrl: alignment, verify/lock, loss filter, reset,
// and (with PCS_ALIGN_STATS_EN) the saturating realign counter.
module tb_pcs_rx_align_ctrl;
  import pcs_rx_align_ctrl_pkg::*;

  // K28.5 + D21.5 bit stream prefixed by "101", cut into 10-bit SerDes words.
  localparam logic [9:0] W0  = 10'b1010011111;
  localparam logic [9:0] W1  = 10'b0101010101;
  localparam logic [9:0] W2  = 10'b0100011111;
  localparam logic [9:0] KCG = 10'b0011111010;
  localparam logic [9:0] DCG = 10'b1010101010;

  logic                clk;
  logic                rst;
  logic                rx_valid_in;
  logic [9:0]          rx_raw;
  logic                sync_status;
  logic [9:0]          rx_code_group;
  logic                pudi;
  logic                aligned;
  logic [OFFSET_W-1:0] offset;
  logic                realign;
`ifdef PCS_ALIGN_STATS_EN
  logic [15:0]         realign_cnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int realignSeen = 0;

  pcs_rx_align_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid_in   (rx_valid_in),
    .rx_raw        (rx_raw),
    .sync_status   (sync_status),
    .rx_code_group (rx_code_group),
    .pudi          (pudi),
    .aligned       (aligned),
    .offset        (offset),
    .realign       (realign)
`ifdef PCS_ALIGN_STATS_EN
   ,.realign_cnt   (realign_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (realign) realignSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic applyStimulus(input logic valid, input logic [9:0] raw);
    rx_valid_in = valid;
    rx_raw      = raw;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 10'd0);
  endtask

  task automatic resetDut();
    rst         = 1'b0;
    sync_status = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    rx_valid_in = 1'b0;
    rx_raw      = '0;
    sync_status = 1'b0;
    @(negedge clk);
    resetDut();

    checkOutput("rst_offset", 32'(offset), 32'd0);
    checkOutput("rst_pudi", 32'(pudi), 32'd0);
    checkOutput("rst_aligned", 32'(aligned), 32'd0);
    checkOutput("rst_realign", 32'(realign), 32'd0);
    checkOutput("rst_code", 32'(rx_code_group), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(ST_SEARCH));

    // Comma shifted by 3 bits completes in the second word.
    applyStimulus(1'b1, W0);
    checkOutput("t1_w0_pudi", 32'(pudi), 32'd1);
    checkOutput("t1_w0_state", 32'(dut.state_q), 32'(ST_SEARCH));
    applyStimulus(1'b1, W1);
    checkOutput("t1_offset", 32'(offset), 32'd3);
    checkOutput("t1_state", 32'(dut.state_q), 32'(ST_VERIFY));
    checkOutput("t1_code_w1", 32'(rx_code_group), 32'(W0));
    applyStimulus(1'b1, W2);
    checkOutput("t1_code_d", 32'(rx_code_group), 32'(DCG));
    applyStimulus(1'b1, W1);
    checkOutput("t1_code_k", 32'(rx_code_group), 32'(KCG));

    // Words 3..9 in VERIFY, sync arrives with word 10.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, (i % 2 == 0) ? W2 : W1);
    checkOutput("t2_pre_aligned", 32'(aligned), 32'd0);
    sync_status = 1'b1;
    applyStimulus(1'b1, W1);
    checkOutput("t2_aligned", 32'(aligned), 32'd1);
    checkOutput("t2_state", 32'(dut.state_q), 32'(ST_LOCKED));
    checkOutput("t2_no_realign", 32'(realignSeen), 32'd0);

    // Loss filter: 7 low cycles tolerated, 8 trigger a re-search.
    sync_status = 1'b0;
    idle(7);
    checkOutput("t4_low7_aligned", 32'(aligned), 32'd1);
    checkOutput("t4_idle_pudi", 32'(pudi), 32'd0);
    sync_status = 1'b1;
    idle(1);
    sync_status = 1'b0;
    idle(7);
    checkOutput("t4_low7b_realign", 32'(realign), 32'd0);
    checkOutput("t4_low7b_aligned", 32'(aligned), 32'd1);
    idle(1);
    checkOutput("t4_low8_realign", 32'(realign), 32'd1);
    checkOutput("t4_low8_aligned", 32'(aligned), 32'd0);
    checkOutput("t4_low8_state", 32'(dut.state_q), 32'(ST_SEARCH));
    idle(1);
    checkOutput("t4_pulse_once", 32'(realign), 32'd0);
    checkOutput("t4_realign_count", 32'(realignSeen), 32'd1);

    // VERIFY timeout after 64 valid words without sync.
    resetDut();
    applyStimulus(1'b1, W0);
    applyStimulus(1'b1, W1);
    checkOutput("t3_enter_verify", 32'(dut.state_q), 32'(ST_VERIFY));
    for (int i = 0; i < 63; i++) applyStimulus(1'b1, W1);
    checkOutput("t3_w63_state", 32'(dut.state_q), 32'(ST_VERIFY));
    checkOutput("t3_w63_realign", 32'(realign), 32'd0);
    applyStimulus(1'b1, W1);
    checkOutput("t3_w64_realign", 32'(realign), 32'd1);
    checkOutput("t3_w64_state", 32'(dut.state_q), 32'(ST_SEARCH));
    checkOutput("t3_w64_aligned", 32'(aligned), 32'd0);
    checkOutput("t3_realign_count", 32'(realignSeen), 32'd2);

    // Commas at offsets 2 and 7 in one window, then reset mid-VERIFY.
    resetDut();
    applyStimulus(1'b1, 10'b1000111110);
    checkOutput("t5_no_early", 32'(dut.state_q), 32'(ST_SEARCH));
    applyStimulus(1'b1, 10'b0000000000);
    checkOutput("t5_offset", 32'(offset), 32'd2);
    checkOutput("t5_state", 32'(dut.state_q), 32'(ST_VERIFY));
    applyStimulus(1'b1, W1);
    checkOutput("t5_pudi", 32'(pudi), 32'd1);
    rst = 1'b0;
    applyStimulus(1'b1, W2);
    checkOutput("t5_rst_offset", 32'(offset), 32'd0);
    checkOutput("t5_rst_pudi", 32'(pudi), 32'd0);
    checkOutput("t5_rst_state", 32'(dut.state_q), 32'(ST_SEARCH));
    checkOutput("t5_rst_code", 32'(rx_code_group), 32'd0);
    rst = 1'b1;

`ifdef PCS_ALIGN_STATS_EN
    resetDut();
    checkOutput("t6_rst_cnt", 32'(realign_cnt), 32'd0);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, W0);
      applyStimulus(1'b1, W1);
      sync_status = 1'b1;
      idle(1);
      sync_status = 1'b0;
      idle(8);
    end
    checkOutput("t6_cnt3", 32'(realign_cnt), 32'd3);
    force dut.realign_cnt_q = 16'hFFFE;
    #1;
    release dut.realign_cnt_q;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, W0);
      applyStimulus(1'b1, W1);
      sync_status = 1'b1;
      idle(1);
      sync_status = 1'b0;
      idle(8);
    end
    checkOutput("t6_saturate", 32'(realign_cnt), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
